clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run-time controller for the programmable clock-divider datapath: produces `divided_clk` from `clk` by an integer ratio N.
- Accepts ratio updates over a valid/ready config port and applies each one only at a period boundary, so no runt pulses occur.
- Starts and stops the divided output cleanly, always ending a period before parking low.
- Sits between the config/register block and the downstream logic that consumes `divided_clk` and `tick`.

Parameters:
- CNT_W, 8, width of the period counter and of the ratio field; legal N is 2..2^CNT_W-1.
- DEFAULT_DIV, 4, ratio loaded at reset; must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  CNT_W  offered ratio N.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- cfg_err  out  1  one-cycle pulse: the accepted ratio was illegal (<2) and was discarded.
- divided_clk  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse in the first clk cycle of each divided period (the cycle `divided_clk` rises).
- running  out  1  1 in the RUN and STOPPING states.

Behaviour:
- Reset values (one cycle of rst=1):
  - state=STOP, cnt=0, div=DEFAULT_DIV, pend=0.
  - divided_clk=0, tick=0, cfg_ready=1, cfg_err=0, running=0.
- Waveform in RUN and STOPPING:
  - cnt counts 0..div-1 and wraps.
  - divided_clk=1 while cnt < (div>>1), otherwise 0. High time is floor(N/2) cycles; low time is ceil(N/2) cycles.
  - tick=1 exactly when cnt==0.
  - All outputs are registered and change on the same edge as cnt.
- States:
  - STOP: cnt=0, divided_clk=0. If en=1, go to RUN. The first RUN cycle has cnt=0, divided_clk=1, tick=1, so latency from en rising to divided_clk rising is 1 clk.
  - RUN: if en=0 in a cycle where cnt != div-1, go to STOPPING. If en=0 in the wrap cycle (cnt==div-1), go straight to STOP.
  - STOPPING: keeps counting normally. At cnt==div-1, go to STOP; the next cycle has divided_clk=0. If en returns to 1 before the wrap, go back to RUN with no disturbance to the waveform or the count.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !pend.
  - An accepted legal value is latched into pend_div and sets pend=1.
  - An illegal value (cfg_div<2) is not latched: cfg_err pulses on the next cycle, and div and pend are unchanged.
- When a pending ratio is applied:
  - In STOP, a legal accepted ratio loads div on the next cycle and pend stays 0.
  - In RUN or STOPPING, pend_div loads into div at the wrap (cnt==div-1 → cnt=0), and pend clears on that same edge. cfg_ready is therefore 1 in the first cycle of the new period.
  - Simultaneous case: a legal ratio accepted in the wrap cycle itself bypasses pend and takes effect for the period beginning on the next cycle.
  - A pending ratio still outstanding when STOPPING reaches its wrap is applied on that same edge.
- Width rules:
  - cnt and div are CNT_W bits unsigned.
  - The compare uses div-1 computed in CNT_W bits; this is safe because div >= 2.
- Reset mid-operation: rst overrides everything in the same cycle. Any pending ratio is lost and div returns to DEFAULT_DIV.

Decomposition:
- Shared package `clk_div_pkg`:
  - state enum {STOP, RUN, STOPPING};
  - MIN_DIV=2;
  - the cfg record type {div}.
- Natural sub-module: `clk_div_core`, holding the counter, compare and output registers, with inputs run, div_load and div_val.
- The FSM and config handshake stay in `clk_div_ctrl`.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=4 → divided_clk pattern 1,1,0,0 repeating; tick on every 4th cycle starting at cycle 1 after en; running=1.
- While running at N=4, send cfg_div=6 mid-period → cfg_ready=0 until the wrap; the next period is 1,1,1,0,0,0 and cfg_ready=1 in its first cycle.
- cfg_div=6 with cfg_valid asserted exactly in the wrap cycle → the new period starts at N=6 immediately; pend never set.
- cfg_div=1, then cfg_div=0 → cfg_err pulses once per transfer; ratio stays 4; waveform unchanged.
- N=5, drop en at cnt=1 → STOPPING completes cnt 2..4, then divided_clk=0 and running=0. Re-raise en at cnt=3 in a second trial → waveform continues with no gap.
- N=3, rst pulsed at cnt=1 with a ratio pending → next cycle divided_clk=0, running=0, cfg_ready=1. A following en=1 produces the N=4 pattern.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the clock-divider controller
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;
  localparam int DIV_W   = 8;

  // Pending-ratio record; its width matches the default counter width.
  typedef struct packed {
    logic [DIV_W-1:0] div;
  } cfg_t;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter, ratio register and registered divided-clock outputs
module clk_div_core #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             wrap,
  output logic             divided_clk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             run_q, run_d;
  logic             dclk_q, dclk_d;
  logic             tick_q, tick_d;

  // div_q >= 2 always holds, so div_q-1 never underflows.
  assign wrap = run_q && (cnt_q == (div_q - CNT_W'(1)));

  always_comb begin
    run_d  = run;
    div_d  = div_load ? div_val : div_q;
    cnt_d  = '0;
    dclk_d = 1'b0;
    tick_d = 1'b0;
    if (run) begin
      if (run_q && !wrap) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      dclk_d = (cnt_d < (div_d >> 1));
      tick_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      run_q  <= 1'b0;
      dclk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      run_q  <= run_d;
      dclk_q <= dclk_d;
      tick_q <= tick_d;
    end
  end

  assign divided_clk = dclk_q;
  assign tick        = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop FSM and ratio handshake around the divider core
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DIV_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             divided_clk,
  output logic             tick,
  output logic             running
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  cfg_t             pend_cfg_q, pend_cfg_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wrap;
  logic             xfer;
  logic             legal;
  logic             div_load;
  logic [CNT_W-1:0] div_val;

  assign cfg_ready = !pend_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_div >= CNT_W'(MIN_DIV));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_cfg_d = pend_cfg_q;
    cfg_err_d  = xfer && !legal;
    div_load   = 1'b0;
    div_val    = CNT_W'(pend_cfg_q.div);

    unique case (state_q)
      STOP:     if (en) state_d = RUN;
      RUN:      if (!en) state_d = wrap ? STOP : STOPPING;
      STOPPING: begin
        if (en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = STOP;
        end
      end
      default:  state_d = STOP;
    endcase

    // Ratios only change at a period boundary, or immediately while parked.
    if (state_q == STOP) begin
      if (xfer && legal) begin
        div_load = 1'b1;
        div_val  = cfg_div;
      end
    end else if (wrap) begin
      if (pend_q) begin
        div_load = 1'b1;
        pend_d   = 1'b0;
      end else if (xfer && legal) begin
        div_load = 1'b1;
        div_val  = cfg_div;
      end
    end else if (xfer && legal) begin
      pend_d         = 1'b1;
      pend_cfg_d.div = DIV_W'(cfg_div);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STOP;
      pend_q     <= 1'b0;
      pend_cfg_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_cfg_q <= pend_cfg_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  clk_div_core #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .run        (state_d != STOP),
    .div_load   (div_load),
    .div_val    (div_val),
    .wrap       (wrap),
    .divided_clk(divided_clk),
    .tick       (tick)
  );

  assign cfg_err = cfg_err_q;
  assign running = (state_q != STOP);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed table-driven bench for clk_div_ctrl
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             divided_clk;
  logic             tick;
  logic             running;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .divided_clk(divided_clk),
    .tick       (tick),
    .running    (running)
  );

  // exp bits: {divided_clk, tick, cfg_ready, cfg_err, running}
  typedef struct {
    logic             en;
    logic             vld;
    logic [CNT_W-1:0] div;
    logic [4:0]       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic e, input logic v, input logic [CNT_W-1:0] d,
                              input logic [4:0] x);
    vec_t r;
    r.en  = e;
    r.vld = v;
    r.div = d;
    r.exp = x;
    tbl.push_back(r);
  endfunction

  task automatic drive(input logic e, input logic v, input logic [CNT_W-1:0] d);
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [4:0] x);
    logic [4:0] act;
    act = {divided_clk, tick, cfg_ready, cfg_err, running};
    n_cmp++;
    if (act !== x) begin
      n_bad++;
      $display("FAIL %s: dclk/tick/rdy/err/run got %b want %b", name, act, x);
    end
  endtask

  task automatic apply(input string name, input logic e, input logic v,
                       input logic [CNT_W-1:0] d, input logic [4:0] x);
    drive(e, v, d);
    step();
    check(name, x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    step();
    check("reset", 5'b00100);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;

    // N=4 run, mid-period ratio 6, wrap-cycle bypass back to 4, illegal ratios
    add(1, 0, 0, 5'b11101); add(1, 0, 0, 5'b10101); add(1, 0, 0, 5'b00101); add(1, 0, 0, 5'b00101);
    add(1, 0, 0, 5'b11101); add(1, 0, 0, 5'b10101);
    add(1, 1, 6, 5'b00001); add(1, 0, 0, 5'b00001);
    add(1, 0, 0, 5'b11101); add(1, 0, 0, 5'b10101); add(1, 0, 0, 5'b10101);
    add(1, 0, 0, 5'b00101); add(1, 0, 0, 5'b00101); add(1, 0, 0, 5'b00101);
    add(1, 1, 4, 5'b11101); add(1, 0, 0, 5'b10101); add(1, 0, 0, 5'b00101); add(1, 0, 0, 5'b00101);
    add(1, 0, 0, 5'b11101);
    add(1, 1, 1, 5'b10111); add(1, 1, 0, 5'b00111); add(1, 0, 0, 5'b00101);
    add(1, 0, 0, 5'b11101); add(1, 0, 0, 5'b10101);

    do_reset();
    foreach (tbl[i]) begin
      apply($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].vld, tbl[i].div, tbl[i].exp);
    end

    // N=5 loaded while parked, en dropped at cnt=1: three STOPPING cycles then park
    do_reset();
    apply("stop_load5", 0, 1, 5, 5'b00100);
    apply("n5_cnt0", 1, 0, 0, 5'b11101);
    apply("n5_cnt1", 1, 0, 0, 5'b10101);
    drive(1'b0, 1'b0, '0);
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      cyc++;
      if (!running) break;
    end
    n_cmp++;
    if (cyc != 4 || running !== 1'b0 || divided_clk !== 1'b0 || tick !== 1'b0) begin
      n_bad++;
      $display("FAIL stopping_drain: cycles %0d run %b dclk %b tick %b want 4 0 0 0",
               cyc, running, divided_clk, tick);
    end

    // en re-raised at cnt=3 while STOPPING: waveform continues without a gap
    apply("rr_cnt0", 1, 0, 0, 5'b11101);
    apply("rr_cnt1", 1, 0, 0, 5'b10101);
    apply("rr_cnt2", 0, 0, 0, 5'b00101);
    apply("rr_cnt3", 0, 0, 0, 5'b00101);
    apply("rr_cnt4", 1, 0, 0, 5'b00101);
    apply("rr_cnt0b", 1, 0, 0, 5'b11101);
    apply("rr_cnt1b", 1, 0, 0, 5'b10101);

    // switch to N=3, pend 7, then reset mid-period
    apply("n3_req", 1, 1, 3, 5'b00001);
    apply("n3_wait3", 1, 0, 0, 5'b00001);
    apply("n3_wait4", 1, 0, 0, 5'b00001);
    apply("n3_cnt0", 1, 0, 0, 5'b11101);
    apply("n3_cnt1", 1, 0, 0, 5'b00101);
    apply("n3_cnt2", 1, 0, 0, 5'b00101);
    apply("n3_cnt0b", 1, 0, 0, 5'b11101);
    apply("n3_pend7", 1, 1, 7, 5'b00001);
    rst = 1'b1;
    apply("mid_reset", 0, 0, 0, 5'b00100);
    rst = 1'b0;
    apply("post_rst_cnt0", 1, 0, 0, 5'b11101);
    apply("post_rst_cnt1", 1, 0, 0, 5'b10101);
    apply("post_rst_cnt2", 1, 0, 0, 5'b00101);
    apply("post_rst_cnt3", 1, 0, 0, 5'b00101);
    apply("wrap_stop", 0, 0, 0, 5'b00100);
    apply("parked", 0, 0, 0, 5'b00100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
